// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
//   Shares one memory port between three CPU requesters (0 = instruction
//   fetch, 1 = data access, 2 = stack access). Round-robin arbitration, one
//   outstanding transaction at a time. The winner's request is latched at the
//   grant edge and held on the memory port until i_mem_ack (or a timeout).
//
// Optional feature (compile-time macro):
//   CPU_BUS_ARB_TIMEOUT_EN  - abort a BUSY transaction after TIMEOUT_CYCLES
//                             cycles without ack (o_done + o_err). Undefined:
//                             BUSY waits forever and o_err is tied low.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_req[2:0]        request per requester
//   i_we[2:0]         write enable per requester
//   i_addr, i_wdata   packed per requester, requester n at [n*W +: W]
//   o_gnt[2:0]        one-hot grant, held for the whole transaction
//   o_done[2:0]       one-cycle completion pulse to the granted requester
//   o_rdata           read data, updated on read completion, held otherwise
//   o_err             transaction aborted (only meaningful with o_done)
//   o_mem_*           memory port: cyc, we, addr, wdata
//   i_mem_rdata       memory read data
//   i_mem_ack         memory completion (one cycle per transaction)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cpu_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2:0]            i_req,
  input  logic [2:0]            i_we,
  input  logic [3*ADDR_W-1:0]   i_addr,
  input  logic [3*DATA_W-1:0]   i_wdata,
  output logic [2:0]            o_gnt,
  output logic [2:0]            o_done,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_err,
  output logic                  o_mem_cyc,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  input  logic                  i_mem_ack
);

  // The BUSY counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("cpu_bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [2:0]          done_q, done_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  // Winner selection: search P, P+1, P+2 (mod 3).
  logic                win_vld;
  logic [1:0]          win_idx;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  always_comb begin
    logic [1:0] cand;
    logic       hit;
    win_vld = 1'b0;
    win_idx = 2'd0;
    // Walk the search order backwards so the highest-priority hit is
    // the last assignment and therefore wins.
    for (int k = 2; k >= 0; k--) begin
      cand = wrap3({1'b0, ptr_q} + 3'(k));
      case (cand)
        2'd0:    hit = i_req[0];
        2'd1:    hit = i_req[1];
        default: hit = i_req[2];
      endcase
      if (hit) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    case (win_idx)
      2'd0: begin
        win_we    = i_we[0];
        win_addr  = i_addr[0*ADDR_W +: ADDR_W];
        win_wdata = i_wdata[0*DATA_W +: DATA_W];
      end
      2'd1: begin
        win_we    = i_we[1];
        win_addr  = i_addr[1*ADDR_W +: ADDR_W];
        win_wdata = i_wdata[1*DATA_W +: DATA_W];
      end
      default: begin
        win_we    = i_we[2];
        win_addr  = i_addr[2*ADDR_W +: ADDR_W];
        win_wdata = i_wdata[2*DATA_W +: DATA_W];
      end
    endcase
  end

  // State register (all state, asynchronous reset).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 3'b000;
      done_q  <= 3'b000;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = 3'b000;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // i_mem_ack is deliberately not looked at here.
        if (win_vld) begin
          state_d = BUSY;
          gnt_d   = 3'b001 << win_idx;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          ptr_d   = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      default: begin
        // Ack has priority over a timeout landing on the same edge.
        if (i_mem_ack) begin
          state_d = IDLE;
          done_d  = gnt_q;
          gnt_d   = 3'b000;
          we_d    = 1'b0;
          if (!we_q) rdata_d = i_mem_rdata;
        end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
        else if (cnt_q >= TO_LAST) begin
          state_d = IDLE;
          done_d  = gnt_q;
          err_d   = 1'b1;
          gnt_d   = 3'b000;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
    endcase
  end

  // Outputs come straight from registers; addr/wdata keep their last value.
  always_comb begin
    o_gnt       = gnt_q;
    o_done      = done_q;
    o_rdata     = rdata_q;
    o_mem_cyc   = (state_q == BUSY);
    o_mem_we    = we_q;
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
    o_err       = err_q;
`else
    o_err       = 1'b0;
`endif
  end

endmodule
